// File: rtl/poly_coef_bank.sv
// poly_coef_bank: double-buffered coefficient store for a Horner-form polynomial
// estimator. Coefficients are written into a shadow bank at any time. A commit
// copies the shadow bank into the active bank, but only while the block is idle.
// On rd_start the active bank is streamed from the highest index down to index 0.
//
// Stream handshake: a beat transfers on a rising edge where coef_valid and
// coef_ready are both high. While coef_valid is high, coef_out, coef_idx and
// coef_last hold steady until that beat transfers. coef_valid never depends
// combinationally on coef_ready.
module poly_coef_bank #(
    parameter int G_POLY_ORDER = 5,
    parameter int G_CWIDTH     = 24,
    localparam int N           = G_POLY_ORDER + 1,
    localparam int AW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [G_CWIDTH-1:0] wr_data,
    input  logic                commit,
    output logic                commit_pending,
    input  logic                rd_start,
    output logic [G_CWIDTH-1:0] coef_out,
    output logic [AW-1:0]       coef_idx,
    output logic                coef_valid,
    input  logic                coef_ready,
    output logic                coef_last,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       coef_idx_q, coef_idx_d;
    logic                pending_q, pending_d;
    logic [G_CWIDTH-1:0] shadow_q [N];
    logic [G_CWIDTH-1:0] shadow_d [N];
    logic [G_CWIDTH-1:0] active_q [N];
    logic [G_CWIDTH-1:0] active_d [N];
    logic                swap;
    logic                beat_done;
    logic                wr_hit;

    // The swap fires in IDLE whenever a commit is pending; enable low blocks it.
    assign swap      = enable && (state_q == ST_IDLE) && pending_q;
    assign beat_done = (state_q == ST_STREAM) && coef_ready;
    assign wr_hit    = wr_en && (wr_addr <= LAST_IDX);

    // State register plus all datapath flops; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            coef_idx_q <= '0;
            pending_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            coef_idx_q <= coef_idx_d;
            pending_q  <= pending_d;
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    // Next-state logic: enable low abandons everything and parks in IDLE.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A pending swap takes priority; a simultaneous rd_start waits one cycle in ARMED.
                    if (pending_q) begin
                        if (rd_start) state_d = ST_ARMED;
                    end else if (rd_start) begin
                        state_d = ST_STREAM;
                    end
                end
                ST_ARMED:  state_d = ST_STREAM;
                ST_STREAM: begin
                    if (beat_done && (coef_idx_q == '0)) state_d = ST_IDLE;
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: index counter, commit flag, shadow writes and the bank swap.
    always_comb begin
        coef_idx_d = coef_idx_q;
        pending_d  = pending_q;
        for (int i = 0; i < N; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = active_q[i];
        end

        // Shadow writes are accepted in every state, even with enable low.
        if (wr_hit) shadow_d[wr_addr] = wr_data;

        // Swap copies the registered shadow, so a write issued alongside commit is already in it.
        if (swap) begin
            for (int i = 0; i < N; i++) active_d[i] = shadow_q[i];
        end

        // A fresh commit re-arms even on the swap edge; otherwise the swap clears it.
        if (commit)    pending_d = 1'b1;
        else if (swap) pending_d = 1'b0;

        if (!enable) begin
            coef_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!pending_q && rd_start) coef_idx_d = LAST_IDX;
                end
                ST_ARMED:  coef_idx_d = LAST_IDX;
                ST_STREAM: begin
                    if (beat_done) coef_idx_d = (coef_idx_q == '0) ? '0 : coef_idx_q - 1'b1;
                end
                default:   coef_idx_d = '0;
            endcase
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        coef_valid     = (state_q == ST_STREAM);
        coef_out       = coef_valid ? active_q[coef_idx_q] : '0;
        coef_idx       = coef_idx_q;
        coef_last      = coef_valid && (coef_idx_q == '0);
        busy           = (state_q != ST_IDLE);
        commit_pending = pending_q;
        dbg_state      = state_q;
    end

endmodule
